// File: rtl/seq_datapath.sv
// Datapath with register file, shifter, ALU, A/B/C pipeline registers and a
// micro-sequencer that runs one whole instruction per accepted command.
module seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rn,
  input  logic [AW-1:0]    cmd_rm,
  input  logic [1:0]       cmd_shift,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  typedef enum logic [2:0] {IDLE, LOADA, LOADB, EXEC, WB} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] a_q, b_q, c_q, imm_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q, rn_q, rm_q;
  logic [1:0]       shift_q;
  logic [2:0]       status_q;

  logic [WIDTH-1:0] bs;
  logic [WIDTH-1:0] alu_out;
  logic             alu_v;

  assign cmd_ready = (state == IDLE) && !reset;
  assign result    = c_q;
  assign status    = status_q;
  assign dbg_data  = regs[dbg_addr];

  always_comb begin
    bs      = b_q;
    alu_out = bs;
    alu_v   = 1'b0;
    case (shift_q)
      2'b01:   bs = b_q << 1;
      2'b10:   bs = b_q >> 1;
      2'b11:   bs = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: bs = b_q;
    endcase
    case (op_q)
      OP_ADD: begin
        alu_out = a_q + bs;
        alu_v   = (a_q[WIDTH-1] == bs[WIDTH-1]) && (alu_out[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_CMP: begin
        alu_out = a_q - bs;
        alu_v   = (a_q[WIDTH-1] != bs[WIDTH-1]) && (alu_out[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_out = a_q & bs;
      OP_MVN:  alu_out = ~bs;
      default: alu_out = bs;
    endcase
  end

  // Operands are latched in LOAD states, so aliasing rd with rn/rm sees old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      imm_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      status_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            rn_q    <= cmd_rn;
            rm_q    <= cmd_rm;
            shift_q <= cmd_shift;
            imm_q   <= cmd_imm;
            case (cmd_op)
              OP_MOVI:                state <= WB;
              OP_MOV, OP_MVN:         state <= LOADB;
              OP_ADD, OP_AND, OP_CMP: state <= LOADA;
              default:                done  <= 1'b1;
            endcase
          end
        end
        LOADA: begin
          a_q   <= regs[rn_q];
          state <= LOADB;
        end
        LOADB: begin
          b_q   <= regs[rm_q];
          state <= EXEC;
        end
        EXEC: begin
          c_q      <= alu_out;
          status_q <= {alu_out[WIDTH-1], alu_v, alu_out == '0};
          if (op_q == OP_CMP) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          if (op_q == OP_MOVI) begin
            regs[rd_q] <= imm_q;
            c_q        <= imm_q;
          end else begin
            regs[rd_q] <= c_q;
          end
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed self-checking bench for seq_datapath; a WIDTH=8 copy runs the same
// command stream in lockstep for the narrow-overflow case.
module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready, cmd_ready8;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [1:0]  cmd_shift;
  logic [15:0] cmd_imm;
  logic        done, done8;
  logic [15:0] result;
  logic [7:0]  result8;
  logic [2:0]  status, status8;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [7:0]  dbg_data8;

  int errors = 0;
  int checks = 0;
  int accepts = 0;

  localparam logic [2:0] MOVI = 3'b000, MOV = 3'b001, ADD = 3'b010,
                         CMP = 3'b011, AND = 3'b100, MVN = 3'b101;

  always #5 clk = ~clk;

  seq_datapath #(.WIDTH(16), .NREG(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .done(done), .result(result),
    .status(status), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  seq_datapath #(.WIDTH(8), .NREG(8)) dut8 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm[7:0]), .done(done8), .result(result8),
    .status(status8), .dbg_addr(dbg_addr), .dbg_data(dbg_data8)
  );

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && !reset) accepts++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkReg(input int idx, input logic [15:0] exp);
    dbg_addr = idx[2:0];
    #1;
    checkOutput($sformatf("R%0d", idx), dbg_data, exp);
  endtask

  // Called at a point where the block is idle; returns at the negedge where done is seen.
  task automatic applyStimulus(input logic [2:0] op, input int rd, input int rn, input int rm,
                               input logic [1:0] sh, input logic [15:0] imm,
                               input int exp_lat, input bit hold);
    int lat;
    int acc0;
    checkOutput("ready_before_cmd", cmd_ready, 1);
    acc0      = accepts;
    cmd_op    = op;
    cmd_rd    = rd[2:0];
    cmd_rn    = rn[2:0];
    cmd_rm    = rm[2:0];
    cmd_shift = sh;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = hold;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      cmd_op    = 3'($urandom);
      cmd_rd    = 3'($urandom);
      cmd_rn    = 3'($urandom);
      cmd_rm    = 3'($urandom);
      cmd_shift = 2'($urandom);
      cmd_imm   = 16'($urandom);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    cmd_valid = 1'b0;
    checkOutput("latency", lat, exp_lat);
    checkOutput("accept_count", accepts - acc0, 1);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    cmd_shift = '0; cmd_imm = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_in_reset", cmd_ready, 0);
    reset = 1'b0;
    #1;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_status", status, 0);
    checkOutput("reset_done", done, 0);
    for (int i = 0; i < 8; i++) checkReg(i, 16'h0000);

    // MOVI/MOVI/ADD with shifted operand
    applyStimulus(MOVI, 0, 0, 0, 2'b00, 16'h0007, 2, 0);
    checkReg(0, 16'h0007);
    checkOutput("movi_result", result, 16'h0007);
    applyStimulus(MOVI, 1, 0, 0, 2'b00, 16'h0002, 2, 0);
    applyStimulus(ADD, 2, 1, 0, 2'b01, 16'h0000, 5, 0);
    checkReg(2, 16'h0010);
    checkOutput("add_result", result, 16'h0010);
    checkOutput("add_status", status, 3'b000);

    // CMP equal operands: Z only, no writeback
    applyStimulus(CMP, 2, 1, 1, 2'b00, 16'h0000, 4, 0);
    checkOutput("cmp_status", status, 3'b001);
    checkOutput("cmp_result", result, 16'h0000);
    checkReg(0, 16'h0007);
    checkReg(1, 16'h0002);
    checkReg(2, 16'h0010);

    // Signed overflow then AND
    applyStimulus(MOVI, 3, 0, 0, 2'b00, 16'h7FFF, 2, 0);
    checkOutput("movi_keeps_status", status, 3'b001);
    applyStimulus(MOVI, 4, 0, 0, 2'b00, 16'h0001, 2, 0);
    applyStimulus(ADD, 5, 3, 4, 2'b00, 16'h0000, 5, 0);
    checkReg(5, 16'h8000);
    checkOutput("ovf_status", status, 3'b110);
    applyStimulus(AND, 6, 5, 5, 2'b00, 16'h0000, 5, 0);
    checkReg(6, 16'h8000);
    checkOutput("and_status", status, 3'b100);

    // MVN with ASR and LSR, MOV with LSL shifting out the MSB
    applyStimulus(MOVI, 0, 0, 0, 2'b00, 16'h8000, 2, 0);
    applyStimulus(MVN, 7, 0, 0, 2'b11, 16'h0000, 4, 0);
    checkReg(7, 16'h3FFF);
    checkOutput("mvn_asr_status", status, 3'b000);
    applyStimulus(MVN, 7, 0, 0, 2'b10, 16'h0000, 4, 0);
    checkReg(7, 16'hBFFF);
    checkOutput("mvn_lsr_status", status, 3'b100);
    applyStimulus(MOV, 1, 0, 0, 2'b01, 16'h0000, 4, 0);
    checkReg(1, 16'h0000);
    checkOutput("mov_lsl_status", status, 3'b001);

    // Reserved op: done only, nothing else moves
    applyStimulus(3'b110, 0, 0, 0, 2'b00, 16'h1234, 1, 0);
    checkOutput("rsv_result", result, 16'h0000);
    checkOutput("rsv_status", status, 3'b001);
    checkReg(0, 16'h8000);

    // Reset while ADD sits in EXEC
    cmd_op = ADD; cmd_rd = 3'd2; cmd_rn = 3'd5; cmd_rm = 3'd5; cmd_shift = 2'b00;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready_in_reset", cmd_ready, 0);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_after", cmd_ready, 1);
    checkOutput("abort_result", result, 0);
    checkReg(2, 16'h0000);
    checkReg(5, 16'h0000);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) bad++;
    end
    checkOutput("abort_no_done", bad, 0);

    // Valid held high with junk fields while busy; aliased operands
    applyStimulus(MOVI, 3, 0, 0, 2'b00, 16'h0005, 2, 1);
    applyStimulus(ADD, 3, 3, 3, 2'b00, 16'h0000, 5, 1);
    checkReg(3, 16'h000A);
    checkOutput("hold_result", result, 16'h000A);

    // Narrow overflow on the WIDTH=8 copy (16-bit copy sees no overflow)
    applyStimulus(MOVI, 3, 0, 0, 2'b00, 16'h007F, 2, 0);
    applyStimulus(MOVI, 4, 0, 0, 2'b00, 16'h0001, 2, 0);
    applyStimulus(ADD, 5, 3, 4, 2'b00, 16'h0000, 5, 0);
    checkOutput("w8_result", result8, 8'h80);
    checkOutput("w8_status", status8, 3'b110);
    dbg_addr = 3'd5;
    #1;
    checkOutput("w8_R5", dbg_data8, 8'h80);
    checkOutput("w16_result", result, 16'h0080);
    checkOutput("w16_status", status, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
